// File: rtl/rx_word_assembler.sv
// Pairs UART byte strobes (LSB first, then MSB) into 16-bit words behind a valid/ack handshake.
// Includes an inter-byte timeout and a saturating overrun counter.
module rx_word_assembler #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [7:0]  Rx_Byte,
    input  logic        Rx_Byte_Valid,
    input  logic        Word_Ack,
    output logic [15:0] Word,
    output logic        Word_Valid,
    output logic        Timeout_Err,
    output logic        Overrun,
    output logic [7:0]  Overrun_Count
);

    typedef enum logic [1:0] {
        WAIT_LSB = 2'd0,
        WAIT_MSB = 2'd1,
        HOLD     = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_d;
    logic        vld_d;
    logic        tmo_d;
    logic        ovr_d;
    logic [7:0]  ovc_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= WAIT_LSB;
            lsb_q         <= 8'd0;
            cnt_q         <= 16'd0;
            Word          <= 16'd0;
            Word_Valid    <= 1'b0;
            Timeout_Err   <= 1'b0;
            Overrun       <= 1'b0;
            Overrun_Count <= 8'd0;
        end else begin
            state_q       <= state_d;
            lsb_q         <= lsb_d;
            cnt_q         <= cnt_d;
            Word          <= word_d;
            Word_Valid    <= vld_d;
            Timeout_Err   <= tmo_d;
            Overrun       <= ovr_d;
            Overrun_Count <= ovc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lsb_d   = lsb_q;
        cnt_d   = cnt_q;
        word_d  = Word;
        vld_d   = Word_Valid;
        tmo_d   = 1'b0;
        ovr_d   = 1'b0;
        ovc_d   = Overrun_Count;

        case (state_q)
            WAIT_LSB: begin
                if (Rx_Byte_Valid) begin
                    lsb_d   = Rx_Byte;
                    cnt_d   = 16'd0;
                    state_d = WAIT_MSB;
                end
            end
            WAIT_MSB: begin
                // A byte arriving on the last allowed cycle beats the timeout.
                if (Rx_Byte_Valid) begin
                    word_d  = {Rx_Byte, lsb_q};
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = WAIT_LSB;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (Word_Ack) begin
                    vld_d = 1'b0;
                    if (Rx_Byte_Valid) begin
                        lsb_d   = Rx_Byte;
                        cnt_d   = 16'd0;
                        state_d = WAIT_MSB;
                    end else begin
                        state_d = WAIT_LSB;
                    end
                end else if (Rx_Byte_Valid) begin
                    ovr_d = 1'b1;
                    if (Overrun_Count != 8'hFF)
                        ovc_d = Overrun_Count + 8'd1;
                end
            end
            default: state_d = WAIT_LSB;
        endcase
    end

endmodule
